// File: rtl/hsv_core_pkg.sv
// Shared core types for the branch unit and its neighbours.
package hsv_core_pkg;

  typedef logic [31:0] word;

  typedef enum logic {
    BRANCH_COND_EQUAL     = 1'b0,
    BRANCH_COND_LESS_THAN = 1'b1
  } branch_cond_t;

  typedef struct packed {
    word        pc;
    word        pc_increment;
    logic [5:0] token;
    logic [4:0] rd;
  } common_data_t;

  typedef struct packed {
    common_data_t common;
    word          rs1;
    word          rs2;
    word          immediate;
    word          predicted;
    branch_cond_t cond;
    logic         cond_signed;
    logic         negate;
    logic         unconditional;
    logic         relative;
    logic         link;
  } branch_data_t;

  typedef struct packed {
    common_data_t common;
    word          result;
    word          next_pc;
    logic         jump;
    logic         trap;
    logic         writeback;
  } commit_data_t;

endpackage

// File: rtl/hsv_core_branch.sv
// Two-stage branch resolution pipeline: S1 compares and forms the target,
// S2 resolves taken/trap/jump into the registered commit output.
module hsv_core_branch
  import hsv_core_pkg::*;
(
  input  logic         clk_core,
  input  logic         rst_core,
  input  logic         flush_req,
  input  branch_data_t branch_data,
  input  logic         branch_valid_i,
  output logic         branch_ready_o,
  output commit_data_t commit_data,
  output logic         commit_valid_o,
  input  logic         commit_ready_i
);

  typedef struct packed {
    common_data_t common;
    word          target;
    word          predicted;
    logic         cond_res;
    logic         unconditional;
    logic         negate;
    logic         link;
  } s1_data_t;

  logic         s1_valid_q, s1_valid_d;
  logic         s2_valid_q, s2_valid_d;
  s1_data_t     s1_q, s1_d;
  commit_data_t s2_q, s2_d;

  logic s2_load, s1_to_s2, in_fire;
  logic cond_res, taken;
  word  target_sum;

  assign s2_load        = !s2_valid_q || commit_ready_i;
  assign s1_to_s2       = s1_valid_q && s2_load;
  assign branch_ready_o = !s1_valid_q || s2_load || flush_req;
  assign in_fire        = branch_valid_i && branch_ready_o;

  // S1: compare and target
  always_comb begin
    cond_res = 1'b0;
    unique case (branch_data.cond)
      BRANCH_COND_EQUAL:     cond_res = (branch_data.rs1 == branch_data.rs2);
      BRANCH_COND_LESS_THAN: begin
        if (branch_data.cond_signed) begin
          cond_res = $signed(branch_data.rs1) < $signed(branch_data.rs2);
        end else begin
          cond_res = branch_data.rs1 < branch_data.rs2;
        end
      end
      default:               cond_res = 1'b0;
    endcase

    target_sum = (branch_data.relative ? branch_data.common.pc : branch_data.rs1)
                 + branch_data.immediate;

    s1_d               = s1_q;
    s1_d.common        = branch_data.common;
    s1_d.target        = branch_data.relative ? target_sum : {target_sum[31:1], 1'b0};
    s1_d.predicted     = branch_data.predicted;
    s1_d.cond_res      = cond_res;
    s1_d.unconditional = branch_data.unconditional;
    s1_d.negate        = branch_data.negate;
    s1_d.link          = branch_data.link;
  end

  // S2: resolve
  always_comb begin
    taken          = s1_q.unconditional | (s1_q.cond_res ^ s1_q.negate);
    s2_d           = s2_q;
    s2_d.common    = s1_q.common;
    s2_d.result    = s1_q.common.pc_increment;
    s2_d.next_pc   = taken ? s1_q.target : s1_q.common.pc_increment;
    s2_d.trap      = taken && (s1_q.target[1:0] != 2'b00);
    s2_d.jump      = !s2_d.trap && (s2_d.next_pc != s1_q.predicted);
    s2_d.writeback = s1_q.link && !s2_d.trap;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_req) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_load) s2_valid_d = s1_valid_q;
      if (in_fire) begin
        s1_valid_d = 1'b1;
      end else if (s1_to_s2) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire)  s1_q <= s1_d;
      if (s1_to_s2) s2_q <= s2_d;
    end
  end

  assign commit_data    = s2_q;
  assign commit_valid_o = s2_valid_q;

endmodule
